// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receive and transmit blocks.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_state_t;

    localparam logic UART_IDLE_LEVEL = 1'b1;
    localparam int   UART_DATA_BITS  = 8;
    localparam int   UART_OVERSAMPLE = 16;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for asynchronous line inputs.
// It resets to the idle line level so that reset cannot look like a start bit.
module uart_rx_sync
    import uart_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // NOTE: sequential state uses non-blocking assignments so both flops sample together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= {WIDTH{UART_IDLE_LEVEL}};
            q    <= {WIDTH{UART_IDLE_LEVEL}};
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver. It oversamples the line and takes a 3-sample majority vote at mid-bit.
// The received byte is held in a one-deep register with a valid/ack handshake.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int DIV   = (CLK_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(UART_DATA_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(OVERSAMPLE / 2);
    localparam logic [CNT_W-1:0] CNT_S2   = CNT_W'(OVERSAMPLE / 2 + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(UART_DATA_BITS - 1);

    if (DIV < 1) begin : g_bad_div
        $error("uart_rx: CLK_HZ/(BAUD*OVERSAMPLE) rounds to zero");
    end
    if ((OVERSAMPLE < 8) || (OVERSAMPLE % 2 != 0)) begin : g_bad_os
        $error("uart_rx: OVERSAMPLE must be even and at least 8");
    end

    logic                        rx_s;
    uart_state_t                 state, state_nxt;
    logic        [DIV_W-1:0]     div_cnt;
    logic        [CNT_W-1:0]     cnt;
    logic        [1:0]           samp;
    logic                        vote_bit;
    logic        [BIT_W-1:0]     bit_idx;
    logic        [7:0]           shift;
    logic                        byte_done;
    logic                        tick, vote, at_vote, at_last, start_frame;

    uart_rx_sync #(.WIDTH(1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    assign tick        = (div_cnt == DIV_LAST);
    assign at_vote     = tick && (cnt == CNT_S2);
    assign at_last     = tick && (cnt == CNT_LAST);
    assign vote        = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);
    assign start_frame = (state == IDLE) && (rx_s != UART_IDLE_LEVEL);
    assign rx_busy     = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: state_nxt gets its default first so no path through the case infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start_frame) state_nxt = START;
            START: begin
                if (at_vote && vote) state_nxt = IDLE;
                else if (at_last)    state_nxt = DATA;
            end
            DATA:  if (at_last && (bit_idx == BIT_LAST)) state_nxt = STOP;
            STOP:  if (at_vote) state_nxt = vote ? IDLE : BREAK;
            BREAK: if (rx_s == UART_IDLE_LEVEL) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt   <= '0;
            cnt       <= '0;
            samp      <= '1;
            vote_bit  <= 1'b1;
            bit_idx   <= '0;
            shift     <= '0;
            byte_done <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            // Bit timing restarts on the start-bit edge so mid-bit samples stay centred.
            if (start_frame) begin
                div_cnt <= '0;
                cnt     <= '0;
            end else if (tick) begin
                div_cnt <= '0;
                cnt     <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            if (tick && (cnt == CNT_S0)) samp[0] <= rx_s;
            if (tick && (cnt == CNT_S1)) samp[1] <= rx_s;
            if (at_vote)                 vote_bit <= vote;

            if ((state == START) && at_last) bit_idx <= '0;
            if ((state == DATA) && at_last) begin
                shift   <= {vote_bit, shift[7:1]};
                bit_idx <= bit_idx + 1'b1;
            end

            if ((state == STOP) && at_vote) begin
                if (vote) byte_done <= 1'b1;
                else      frame_err <= 1'b1;
            end

            // An ack in the delivery cycle frees the register for the incoming byte.
            if (byte_done) begin
                if (!rx_valid || rx_ack) begin
                    rx_data  <= shift;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ack) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit. Expected bytes are pushed into a
// scoreboard queue and a negedge monitor pops and compares each one the DUT presents.
module tb_uart_rx;

    localparam int BIT_CLK = 16;
    localparam int FRAME   = 10 * BIT_CLK;
    localparam int LAT_MAX = 2 + 1 * (9 * 16 + 8 + 2) + 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun;

    int         total = 0;
    int         bad = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    logic [7:0] exp_q[$];
    logic       auto_ack = 1'b0;
    logic       force_ack = 1'b0;
    logic       prev_valid = 1'b0;
    logic       prev_taken = 1'b0;
    int         lat;

    uart_rx #(.CLK_HZ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ack    (rx_ack),
        .rx_busy   (rx_busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one frame starting just after a rising edge; glitch_bit >= 0 inverts rx for
    // one clock in the middle of that data bit. Cycles past the frame hold the line low.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                              input int glitch_bit, input int ncyc);
        logic [9:0] frame;
        int         idx;
        frame = {stop_bit, data, 1'b0};
        for (int c = 0; c < ncyc; c++) begin
            idx = c / BIT_CLK;
            rx  = (idx < 10) ? frame[idx] : 1'b0;
            if (glitch_bit >= 0 && idx - 1 == glitch_bit && c % BIT_CLK == 9) rx = ~rx;
            @(posedge clk); #1;
        end
        rx = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        #2;
        rx_ack = (auto_ack && rx_valid) || force_ack;
    end

    // Scoreboard monitor: a new byte is present when rx_valid rises or stays high
    // right after a completed handshake.
    always @(negedge clk) begin
        if (reset) begin
            prev_valid = 1'b0;
            prev_taken = 1'b0;
        end else begin
            if (rx_valid && (!prev_valid || prev_taken)) begin
                check("sb_byte_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) check("sb_rx_data", rx_data, exp_q.pop_front());
            end
            if (frame_err) fe_cnt++;
            if (overrun)   ov_cnt++;
            if (frame_err || overrun) check("flags_exclusive", frame_err & overrun, 1'b0);
            prev_valid = rx_valid;
            prev_taken = rx_valid && rx_ack;
        end
    end

    initial begin
        rx     = 1'b1;
        rx_ack = 1'b0;
        reset  = 1'b1;
        idle(3);
        check("reset_rx_valid", rx_valid, 1'b0);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_busy", rx_busy, 1'b0);
        check("reset_flags", {frame_err, overrun}, 2'b00);
        reset = 1'b0;
        idle(2);

        // Single frame, no ack, latency bound
        exp_q.push_back(8'h55);
        lat = 0;
        fork
            send_frame(8'h55, 1'b1, -1, FRAME);
            begin
                for (int i = 1; i <= LAT_MAX; i++) begin
                    @(posedge clk); #1;
                    if (rx_valid) begin
                        lat = i;
                        break;
                    end
                end
            end
        join
        check("t1_valid_within_bound", (lat > 0) && (lat <= LAT_MAX), 1'b1);
        idle(10);
        check("t1_rx_data", rx_data, 8'h55);
        check("t1_rx_valid_held", rx_valid, 1'b1);
        check("t1_no_flags", fe_cnt + ov_cnt, 0);

        // Back-to-back frames with ack on each
        auto_ack = 1'b1;
        idle(4);
        check("t2_ack_clears_valid", rx_valid, 1'b0);
        exp_q.push_back(8'hA3);
        exp_q.push_back(8'h0F);
        send_frame(8'hA3, 1'b1, -1, FRAME);
        send_frame(8'h0F, 1'b1, -1, FRAME);
        idle(10);
        check("t2_sb_drained", exp_q.size(), 0);
        check("t2_rx_data_last", rx_data, 8'h0F);

        // Short start-bit glitch is rejected
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        check("t3_busy_during_start", rx_busy, 1'b1);
        idle(10);
        check("t3_busy_returns_idle", rx_busy, 1'b0);
        idle(20);
        check("t3_no_valid", rx_valid, 1'b0);
        check("t3_no_flags", fe_cnt + ov_cnt, 0);

        // Framing error, held break, then recovery
        send_frame(8'h3C, 1'b0, -1, FRAME + 40);
        check("t4_one_frame_err", fe_cnt, 1);
        check("t4_no_valid", rx_valid, 1'b0);
        check("t4_busy_in_break", rx_busy, 1'b1);
        idle(5);
        check("t4_break_exit", rx_busy, 1'b0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, -1, FRAME);
        idle(10);
        check("t4_rx_data_81", rx_data, 8'h81);
        check("t4_frame_err_count", fe_cnt, 1);

        // Overrun without ack, then delivery coinciding with ack
        auto_ack = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, -1, FRAME);
        send_frame(8'h22, 1'b1, -1, FRAME);
        idle(10);
        check("t5_overrun_once", ov_cnt, 1);
        check("t5_rx_data_kept", rx_data, 8'h11);
        check("t5_rx_valid_kept", rx_valid, 1'b1);
        force_ack = 1'b1;
        idle(1);
        force_ack = 1'b0;
        idle(3);
        check("t5_ack_clears", rx_valid, 1'b0);
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, -1, FRAME);
        exp_q.push_back(8'h22);
        fork
            send_frame(8'h22, 1'b1, -1, FRAME);
            begin
                repeat (FRAME - 3) @(posedge clk);
                #1 force_ack = 1'b1;
                @(posedge clk);
                #1 force_ack = 1'b0;
            end
        join
        idle(5);
        check("t5_coincident_data", rx_data, 8'h22);
        check("t5_coincident_valid", rx_valid, 1'b1);
        check("t5_no_new_overrun", ov_cnt, 1);

        // Reset in the middle of data bit 4
        send_frame(8'hFF, 1'b1, -1, 5 * BIT_CLK + 8);
        reset = 1'b1;
        #1;
        check("t6_reset_outputs", {rx_data, rx_valid, rx_busy, frame_err, overrun}, 12'h000);
        check("t6_sb_empty", exp_q.size(), 0);
        idle(3);
        reset = 1'b0;
        idle(2);
        auto_ack = 1'b1;
        exp_q.push_back(8'h42);
        send_frame(8'h42, 1'b1, -1, FRAME);
        idle(10);
        check("t6_rx_data_42", rx_data, 8'h42);

        // Single-clock glitches inside data bits are outvoted
        exp_q.push_back(8'hC6);
        send_frame(8'hC6, 1'b1, 5, FRAME);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 0, FRAME);
        exp_q.push_back(8'h80);
        send_frame(8'h80, 1'b1, 7, FRAME);
        idle(10);
        check("glitch_sb_drained", exp_q.size(), 0);
        check("final_frame_err_count", fe_cnt, 1);
        check("final_overrun_count", ov_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
